// File: rtl/demux_1to2_buf_if.sv
// Handshake bundle for demux_1to2_buf: one producer stream in, two consumer streams out.
// With DEMUX_STAT_EN defined the bundle also carries the per-channel pop counters.
interface demux_1to2_buf_if #(
   parameter int unsigned size = 32
);
   logic [size-1:0] data_i;
   logic            select_i;
   logic            valid_i;
   logic            ready_o;

   logic [size-1:0] data0_o;
   logic            valid0_o;
   logic            ready0_i;

   logic [size-1:0] data1_o;
   logic            valid1_o;
   logic            ready1_i;

`ifdef DEMUX_STAT_EN
   logic [7:0]      pop0_cnt_o;
   logic [7:0]      pop1_cnt_o;
`endif

   // Demux side
   modport slave (
      input  data_i, select_i, valid_i, ready0_i, ready1_i,
      output ready_o, data0_o, valid0_o, data1_o, valid1_o
`ifdef DEMUX_STAT_EN
      , output pop0_cnt_o, pop1_cnt_o
`endif
   );

   // Producer/consumer side
   modport master (
      output data_i, select_i, valid_i, ready0_i, ready1_i,
      input  ready_o, data0_o, valid0_o, data1_o, valid1_o
`ifdef DEMUX_STAT_EN
      , input pop0_cnt_o, pop1_cnt_o
`endif
   );
endinterface

// File: rtl/demux_1to2_buf.sv
// Sequential 1-to-2 demux: steers a valid/ready stream into one of two 2-entry FIFOs.
// Optional feature macro DEMUX_STAT_EN adds saturating 8-bit pop counters per channel.
module demux_1to2_buf #(
   parameter int unsigned size = 32
) (
   input logic             clk_i,
   input logic             rst_i,
   demux_1to2_buf_if.slave bus
);
   localparam int unsigned NCH   = 2;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [size-1:0]  mem    [NCH][DEPTH];
   logic             wr_ptr [NCH];
   logic             rd_ptr [NCH];
   logic [CNT_W-1:0] cnt    [NCH];

   logic [NCH-1:0]   full_c;
   logic [NCH-1:0]   valid_c;
   logic [NCH-1:0]   rdy_c;
   logic [NCH-1:0]   push_c;
   logic [NCH-1:0]   pop_c;
   logic             ready_c;

   // Acceptance uses the occupancy at the edge only; a same-cycle pop never frees a full FIFO.
   always_comb begin
      full_c  = '0;
      valid_c = '0;
      push_c  = '0;
      rdy_c   = {bus.ready1_i, bus.ready0_i};
      for (int ch = 0; ch < NCH; ch++) begin
         full_c[ch]  = (cnt[ch] == CNT_FULL);
         valid_c[ch] = (cnt[ch] != '0);
      end
      ready_c = bus.select_i ? !full_c[1] : !full_c[0];
      if (bus.valid_i && ready_c) begin
         push_c[bus.select_i] = 1'b1;
      end
      pop_c = valid_c & rdy_c;
   end

   // FIFO storage, pointers and occupancy; both channels update independently.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int ch = 0; ch < NCH; ch++) begin
            wr_ptr[ch] <= 1'b0;
            rd_ptr[ch] <= 1'b0;
            cnt[ch]    <= '0;
            for (int e = 0; e < DEPTH; e++) begin
               mem[ch][e] <= '0;
            end
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (push_c[ch]) begin
               mem[ch][wr_ptr[ch]] <= bus.data_i;
               wr_ptr[ch]          <= ~wr_ptr[ch];
            end
            if (pop_c[ch]) begin
               rd_ptr[ch] <= ~rd_ptr[ch];
            end
            case ({push_c[ch], pop_c[ch]})
               2'b10:   cnt[ch] <= cnt[ch] + CNT_W'(1);
               2'b01:   cnt[ch] <= cnt[ch] - CNT_W'(1);
               default: cnt[ch] <= cnt[ch];
            endcase
         end
      end
   end

   assign bus.ready_o  = ready_c;
   assign bus.data0_o  = mem[0][rd_ptr[0]];
   assign bus.valid0_o = valid_c[0];
   assign bus.data1_o  = mem[1][rd_ptr[1]];
   assign bus.valid1_o = valid_c[1];

`ifdef DEMUX_STAT_EN
   localparam int unsigned STAT_W = 8;

   logic [STAT_W-1:0] pop_cnt [NCH];

   // Completed-pop counters, saturating instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int ch = 0; ch < NCH; ch++) begin
            pop_cnt[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            if (pop_c[ch] && (pop_cnt[ch] != '1)) begin
               pop_cnt[ch] <= pop_cnt[ch] + STAT_W'(1);
            end
         end
      end
   end

   assign bus.pop0_cnt_o = pop_cnt[0];
   assign bus.pop1_cnt_o = pop_cnt[1];
`endif

`ifndef SYNTHESIS
   for (genvar g = 0; g < NCH; g++) begin : g_chk
      a_cnt_range:   assert property (@(posedge clk_i) disable iff (!rst_i) cnt[g] <= CNT_FULL);
      a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_i) !(push_c[g] && full_c[g]));
   end
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Bench for demux_1to2_buf: directed vector table, then random traffic against a queue model.
`timescale 1ns/1ps
module tb_demux_1to2_buf;
   localparam int unsigned W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   demux_1to2_buf_if #(.size(W)) bus ();
   demux_1to2_buf #(.size(W)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] q0 [$];
   logic [W-1:0] q1 [$];
   int pops0 = 0;
   int pops1 = 0;

   typedef struct {
      logic v, s;
      logic [W-1:0] d;
      logic r0, r1;
      logic e_rdy, e_v0;
      logic [W-1:0] e_d0;
      logic e_v1;
      logic [W-1:0] e_d1;
   } vec_t;

   localparam int NVEC = 17;
   vec_t tbl [NVEC];

   function automatic vec_t mk(logic v, logic s, logic [W-1:0] d, logic r0, logic r1,
                               logic e_rdy, logic e_v0, logic [W-1:0] e_d0,
                               logic e_v1, logic [W-1:0] e_d1);
      vec_t t;
      t.v = v; t.s = s; t.d = d; t.r0 = r0; t.r1 = r1;
      t.e_rdy = e_rdy; t.e_v0 = e_v0; t.e_d0 = e_d0; t.e_v1 = e_v1; t.e_d1 = e_d1;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs just after a rising edge, then move to the sampling point.
   task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                        input logic r0, input logic r1);
      bus.valid_i  = v;
      bus.select_i = s;
      bus.data_i   = d;
      bus.ready0_i = r0;
      bus.ready1_i = r1;
      @(negedge clk);
   endtask

   task automatic model_check(input string tag);
      logic e_rdy;
      e_rdy = bus.select_i ? (q1.size() < 2) : (q0.size() < 2);
      chk({tag, " ready"},  64'(bus.ready_o),  64'(e_rdy));
      chk({tag, " valid0"}, 64'(bus.valid0_o), 64'(q0.size() != 0));
      chk({tag, " valid1"}, 64'(bus.valid1_o), 64'(q1.size() != 0));
      if (q0.size() != 0) chk({tag, " data0"}, 64'(bus.data0_o), 64'(q0[0]));
      if (q1.size() != 0) chk({tag, " data1"}, 64'(bus.data1_o), 64'(q1[0]));
`ifdef DEMUX_STAT_EN
      chk({tag, " pop0_cnt"}, 64'(bus.pop0_cnt_o), 64'(pops0));
      chk({tag, " pop1_cnt"}, 64'(bus.pop1_cnt_o), 64'(pops1));
`endif
   endtask

   // Reference transfer rules: accept only into a non-full FIFO, pop any non-empty one.
   task automatic advance();
      logic push, p0, p1;
      push = bus.valid_i && (bus.select_i ? (q1.size() < 2) : (q0.size() < 2));
      p0   = bus.ready0_i && (q0.size() != 0);
      p1   = bus.ready1_i && (q1.size() != 0);
      @(posedge clk);
      if (p0) begin
         void'(q0.pop_front());
         if (pops0 < 255) pops0++;
      end
      if (p1) begin
         void'(q1.pop_front());
         if (pops1 < 255) pops1++;
      end
      if (push) begin
         if (bus.select_i) q1.push_back(bus.data_i);
         else              q0.push_back(bus.data_i);
      end
      #1;
   endtask

   task automatic async_reset(input int hold);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst valid0", 64'(bus.valid0_o), 64'(0));
      chk("async_rst valid1", 64'(bus.valid1_o), 64'(0));
`ifdef DEMUX_STAT_EN
      chk("async_rst pop0_cnt", 64'(bus.pop0_cnt_o), 64'(0));
      chk("async_rst pop1_cnt", 64'(bus.pop1_cnt_o), 64'(0));
`endif
      q0.delete();
      q1.delete();
      pops0 = 0;
      pops1 = 0;
      repeat (hold) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with a valid word presented: nothing may be captured.
      bus.valid_i  = 1'b1;
      bus.select_i = 1'b0;
      bus.data_i   = 32'hAAAA5555;
      bus.ready0_i = 1'b0;
      bus.ready1_i = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("rst valid0", 64'(bus.valid0_o), 64'(0));
         chk("rst valid1", 64'(bus.valid1_o), 64'(0));
         chk("rst data0",  64'(bus.data0_o),  64'(0));
         chk("rst data1",  64'(bus.data1_o),  64'(0));
         chk("rst ready",  64'(bus.ready_o),  64'(1));
      end
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         model_check("post_rst");
         advance();
      end

      // Expected outputs per row reflect state before that row's clock edge.
      tbl[0]  = mk(1, 0, 32'h11, 1, 1,  1, 0, 32'h0,  0, 32'h0);
      tbl[1]  = mk(1, 1, 32'h22, 1, 1,  1, 1, 32'h11, 0, 32'h0);
      tbl[2]  = mk(0, 0, 32'h0,  1, 1,  1, 0, 32'h0,  1, 32'h22);
      tbl[3]  = mk(0, 0, 32'h0,  1, 1,  1, 0, 32'h0,  0, 32'h0);
      tbl[4]  = mk(1, 0, 32'h01, 0, 0,  1, 0, 32'h0,  0, 32'h0);
      tbl[5]  = mk(1, 0, 32'h02, 0, 0,  1, 1, 32'h01, 0, 32'h0);
      tbl[6]  = mk(1, 0, 32'h03, 0, 0,  0, 1, 32'h01, 0, 32'h0);
      tbl[7]  = mk(1, 1, 32'h44, 0, 0,  1, 1, 32'h01, 0, 32'h0);
      tbl[8]  = mk(1, 0, 32'h03, 1, 0,  0, 1, 32'h01, 1, 32'h44);
      tbl[9]  = mk(1, 0, 32'h03, 0, 0,  1, 1, 32'h02, 1, 32'h44);
      tbl[10] = mk(0, 0, 32'h0,  1, 1,  0, 1, 32'h02, 1, 32'h44);
      tbl[11] = mk(1, 1, 32'h55, 1, 0,  1, 1, 32'h03, 0, 32'h0);
      tbl[12] = mk(1, 1, 32'h66, 1, 1,  1, 0, 32'h0,  1, 32'h55);
      tbl[13] = mk(0, 1, 32'h0,  1, 0,  1, 0, 32'h0,  1, 32'h66);
      tbl[14] = mk(0, 1, 32'h0,  1, 0,  1, 0, 32'h0,  1, 32'h66);
      tbl[15] = mk(0, 1, 32'h0,  1, 1,  1, 0, 32'h0,  1, 32'h66);
      tbl[16] = mk(0, 0, 32'h0,  1, 1,  1, 0, 32'h0,  0, 32'h0);

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
         chk($sformatf("vec%0d ready", i),  64'(bus.ready_o),  64'(tbl[i].e_rdy));
         chk($sformatf("vec%0d valid0", i), 64'(bus.valid0_o), 64'(tbl[i].e_v0));
         chk($sformatf("vec%0d valid1", i), 64'(bus.valid1_o), 64'(tbl[i].e_v1));
         if (tbl[i].e_v0) chk($sformatf("vec%0d data0", i), 64'(bus.data0_o), 64'(tbl[i].e_d0));
         if (tbl[i].e_v1) chk($sformatf("vec%0d data1", i), 64'(bus.data1_o), 64'(tbl[i].e_d1));
         advance();
      end

      // Random traffic with varying backpressure, plus an asynchronous reset mid-run.
      for (int i = 0; i < 1500; i++) begin
         logic v, s, r0, r1;
         int bias;
         bias = (i / 250) % 3;
         v  = ($urandom_range(0, 3) != 0);
         s  = 1'($urandom_range(0, 1));
         r0 = (bias == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         r1 = (bias == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         if (i == 700) async_reset(2);
         drive(v, s, W'($urandom), r0, r1);
         model_check("rand");
         advance();
      end

`ifdef DEMUX_STAT_EN
      // Saturation of the pop counters: 300 pops on channel 0, 4 on channel 1.
      async_reset(1);
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0, W'(i), 1'b1, 1'b0);
         model_check("stat0");
         advance();
      end
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      advance();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, W'(i + 1000), 1'b1, 1'b1);
         model_check("stat1");
         advance();
      end
      drive(1'b0, 1'b1, '0, 1'b1, 1'b1);
      advance();
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      chk("stat pop0 saturated", 64'(bus.pop0_cnt_o), 64'(255));
      chk("stat pop1 count",     64'(bus.pop1_cnt_o), 64'(4));
      advance();
      async_reset(1);
`endif

      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      model_check("final");
      advance();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
